uart_tx_arbiter: RTL and testbench

//   Shares the single UART transmitter among N_REQ byte producers (sonar distance reports,

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin sharing of one UART TX write port among N_REQ byte
//            producers; one byte per grant, optional source tag byte when
//            UART_TX_TAG_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int         N_REQ    = 2,
    parameter int         SRC_W    = 2,
    parameter logic [7:0] TAG_BASE = 8'hA0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    input  logic                 tx_rdy,
    output logic                 data_wen,
    output logic [7:0]           data,
    output logic                 busy,
    output logic [SRC_W-1:0]     cur_src
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WAIT_TX_RDY  = 3'd1,
        S_SEND         = 3'd2,
        S_COOL         = 3'd3,
        S_WAIT_TAG_RDY = 3'd4,
        S_SEND_TAG     = 3'd5,
        S_COOL_TAG     = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SRC_W-1:0]   r_rr_last;
    logic [SRC_W-1:0]   w_rr_last_nxt;
    logic [SRC_W-1:0]   w_cur_src_nxt;
    logic [SRC_W-1:0]   w_winner;
    logic [7:0]         w_win_byte;
    logic               w_found;
    int                 w_best;
    int                 w_dist;
    logic [7:0]         r_payload;
    logic [7:0]         w_payload_nxt;
    logic [7:0]         w_data_nxt;
    logic               w_data_wen_nxt;
    logic [N_REQ-1:0]   w_ack_nxt;

    // Winner = pending source with the smallest distance past rr_last (mod N_REQ).
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_byte = '0;
        w_best     = N_REQ;
        w_dist     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - 1 - int'(r_rr_last)) % N_REQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_found    = 1'b1;
                w_winner   = SRC_W'(i);
                w_win_byte = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_data_wen_nxt = 1'b1;
        w_ack_nxt      = '0;
        w_data_nxt     = data;
        w_cur_src_nxt  = cur_src;
        w_payload_nxt  = r_payload;
        w_rr_last_nxt  = r_rr_last;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_cur_src_nxt = w_winner;
                    w_payload_nxt = w_win_byte;
`ifdef UART_TX_TAG_EN
                    w_state_nxt   = S_WAIT_TAG_RDY;
`else
                    w_state_nxt   = S_WAIT_TX_RDY;
`endif
                end
            end
            S_WAIT_TAG_RDY: begin
                if (tx_rdy) begin
                    w_data_nxt     = TAG_BASE | 8'(cur_src);
                    w_data_wen_nxt = 1'b0;
                    w_state_nxt    = S_SEND_TAG;
                end
            end
            S_SEND_TAG:  w_state_nxt = S_COOL_TAG;
            S_COOL_TAG:  w_state_nxt = S_WAIT_TX_RDY;
            S_WAIT_TX_RDY: begin
                if (tx_rdy) begin
                    w_data_nxt     = r_payload;
                    w_data_wen_nxt = 1'b0;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (cur_src == SRC_W'(i)) begin
                            w_ack_nxt[i] = 1'b1;
                        end
                    end
                    w_state_nxt    = S_SEND;
                end
            end
            S_SEND: begin
                w_rr_last_nxt = cur_src;
                w_state_nxt   = S_COOL;
            end
            // COOL covers the UART's tx_rdy fall latency after a strobe.
            S_COOL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            data_wen  <= 1'b1;
            data      <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            cur_src   <= '0;
            r_rr_last <= SRC_W'(N_REQ - 1);
            r_payload <= '0;
        end else begin
            r_state   <= w_state_nxt;
            data_wen  <= w_data_wen_nxt;
            data      <= w_data_nxt;
            ack       <= w_ack_nxt;
            busy      <= (w_state_nxt != S_IDLE);
            cur_src   <= w_cur_src_nxt;
            r_rr_last <= w_rr_last_nxt;
            r_payload <= w_payload_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized requesters against a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int         NR   = 2;
    localparam logic [7:0] TB_TAG = 8'hA0;
`ifdef UART_TX_TAG_EN
    localparam bit TAG = 1'b1;
    localparam int NB  = 2;
`else
    localparam bit TAG = 1'b0;
    localparam int NB  = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  ack;
    logic        tx_rdy = 1'b0;
    logic        data_wen;
    logic [7:0]  data;
    logic        busy;
    logic [1:0]  cur_src;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.N_REQ(NR), .SRC_W(2), .TAG_BASE(TB_TAG)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
        .tx_rdy(tx_rdy), .data_wen(data_wen), .data(data), .busy(busy),
        .cur_src(cur_src)
    );

    always #5 clk = ~clk;

    // Reference model: a grant is a transaction that waits for tx_rdy, then
    // occupies the port for a fixed number of cycles.
    int          mk, m_last, m_from, m_phase, m_src, m_rr;
    logic [7:0]  m_byte;
    logic        e_wen, e_busy;
    logic [1:0]  e_ack, e_src;
    logic [7:0]  e_data;
    logic [7:0]  sq[$];
    logic [1:0]  aq[$];

    task automatic model_reset();
        mk = 0; m_last = -10; m_from = 0; m_phase = 0; m_src = 0; m_rr = NR - 1;
        m_byte = '0; e_data = '0; e_src = '0;
        sq.delete(); aq.delete();
    endtask

    task automatic model_step(input logic [1:0] rq, input logic [15:0] rd, input logic rdy);
        int  w;
        bit  hit;
        e_wen = 1'b1;
        e_ack = '0;
        if (m_phase != 0 && mk >= m_from && rdy) begin
            e_wen = 1'b0;
            if (m_phase == 1) begin
                e_data  = TB_TAG | 8'(m_src);
                m_phase = 2;
                m_from  = mk + 3;
            end else begin
                e_data  = m_byte;
                e_ack   = 2'(1 << m_src);
                m_rr    = m_src;
                m_phase = 0;
                m_last  = mk;
            end
        end else if (m_phase == 0 && mk >= m_last + 3 && rq != 2'b00) begin
            hit = 1'b0;
            w   = 0;
            for (int j = 1; j <= NR; j++) begin
                if (!hit && rq[(m_rr + j) % NR]) begin
                    hit = 1'b1;
                    w   = (m_rr + j) % NR;
                end
            end
            m_src   = w;
            m_byte  = rd[8*w +: 8];
            m_phase = TAG ? 1 : 2;
            m_from  = mk + 1;
        end
        e_busy = (m_phase != 0) || (mk <= m_last + 1);
        e_src  = 2'(m_src);
        mk++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
        end
    endtask

    task automatic cyc(input logic [1:0] rq, input logic [15:0] rd, input logic rdy);
        req = rq; req_data = rd; tx_rdy = rdy;
        model_step(rq, rd, rdy);
        @(posedge clk); #1;
        chk("data_wen", data_wen, e_wen);
        chk("ack", ack, e_ack);
        chk("data", data, e_data);
        chk("busy", busy, e_busy);
        chk("cur_src", cur_src, e_src);
        if (!data_wen) begin
            sq.push_back(data);
            aq.push_back(ack);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wen"}, data_wen, 1'b1);
        chk({tag, "_ack"}, ack, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_data"}, data, 8'h00);
        chk({tag, "_src"}, cur_src, 2'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; req_data = '0; tx_rdy = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0]  rq;
        logic [15:0] rd;
        logic        rdy;
        logic        wen;
        logic [1:0]  ak;
        logic [7:0]  dt;
        logic        bz;
        logic [1:0]  src;
    } vec_t;

    vec_t        tbl [18];
    logic [1:0]  rreq;
    logic [15:0] rdat;
    logic [1:0]  rq;

    initial begin
        tbl[0]  = '{2'b11, 16'h2211, 1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 2'd0};
        tbl[1]  = '{2'b11, 16'h2211, 1'b1, 1'b0, 2'b01, 8'h11, 1'b1, 2'd0};
        tbl[2]  = '{2'b11, 16'h2211, 1'b1, 1'b1, 2'b00, 8'h11, 1'b1, 2'd0};
        tbl[3]  = '{2'b11, 16'h2211, 1'b1, 1'b1, 2'b00, 8'h11, 1'b0, 2'd0};
        tbl[4]  = '{2'b11, 16'h2211, 1'b1, 1'b1, 2'b00, 8'h11, 1'b1, 2'd1};
        tbl[5]  = '{2'b11, 16'h2211, 1'b1, 1'b0, 2'b10, 8'h22, 1'b1, 2'd1};
        tbl[6]  = '{2'b11, 16'h2211, 1'b1, 1'b1, 2'b00, 8'h22, 1'b1, 2'd1};
        tbl[7]  = '{2'b11, 16'h2211, 1'b1, 1'b1, 2'b00, 8'h22, 1'b0, 2'd1};
        tbl[8]  = '{2'b10, 16'h5C11, 1'b0, 1'b1, 2'b00, 8'h22, 1'b1, 2'd1};
        tbl[9]  = '{2'b10, 16'h5C11, 1'b0, 1'b1, 2'b00, 8'h22, 1'b1, 2'd1};
        tbl[10] = '{2'b10, 16'h5C11, 1'b0, 1'b1, 2'b00, 8'h22, 1'b1, 2'd1};
        tbl[11] = '{2'b10, 16'h5C11, 1'b1, 1'b0, 2'b10, 8'h5C, 1'b1, 2'd1};
        tbl[12] = '{2'b00, 16'h5C11, 1'b1, 1'b1, 2'b00, 8'h5C, 1'b1, 2'd1};
        tbl[13] = '{2'b00, 16'h5C11, 1'b1, 1'b1, 2'b00, 8'h5C, 1'b0, 2'd1};
        tbl[14] = '{2'b01, 16'h5C11, 1'b1, 1'b1, 2'b00, 8'h5C, 1'b1, 2'd0};
        tbl[15] = '{2'b00, 16'h5C11, 1'b1, 1'b0, 2'b01, 8'h11, 1'b1, 2'd0};
        tbl[16] = '{2'b00, 16'h5C11, 1'b1, 1'b1, 2'b00, 8'h11, 1'b1, 2'd0};
        tbl[17] = '{2'b00, 16'h5C11, 1'b1, 1'b1, 2'b00, 8'h11, 1'b0, 2'd0};

        model_reset();
        do_reset();

`ifndef UART_TX_TAG_EN
        for (int v = 0; v < 18; v++) begin
            req = tbl[v].rq; req_data = tbl[v].rd; tx_rdy = tbl[v].rdy;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_wen", v), data_wen, tbl[v].wen);
            chk($sformatf("tbl%0d_ack", v), ack, tbl[v].ak);
            chk($sformatf("tbl%0d_data", v), data, tbl[v].dt);
            chk($sformatf("tbl%0d_busy", v), busy, tbl[v].bz);
            chk($sformatf("tbl%0d_src", v), cur_src, tbl[v].src);
        end
`else
        do_reset();
        rq = 2'b10;
        for (int c = 0; c < 9; c++) begin
            cyc(rq, 16'h4400, 1'b1);
            if (ack[1]) rq = 2'b00;
        end
        chk("t6_nstrobe", sq.size(), 2);
        chk("t6_tag", sq[0], 8'hA1);
        chk("t6_payload", sq[1], 8'h44);
        chk("t6_tag_noack", aq[0], 2'b00);
        chk("t6_payload_ack", aq[1], 2'b10);
`endif

        // tx_rdy held low for 20 cycles, then released
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cyc(2'b10, 16'h9E00, 1'b0);
            chk("t3_hold", {data_wen, busy}, 2'b11);
        end
        rq = 2'b10;
        for (int c = 0; c < 8; c++) begin
            cyc(rq, 16'h9E00, 1'b1);
            if (ack[1]) rq = 2'b00;
        end
        chk("t3_nstrobe", sq.size(), NB);
        chk("t3_byte", sq[NB-1], 8'h9E);

        // one-cycle request pulse is still committed
        do_reset();
        cyc(2'b01, 16'h005A, 1'b1);
        for (int c = 0; c < 7; c++) cyc(2'b00, 16'h00FF, 1'b1);
        chk("t4_nstrobe", sq.size(), NB);
        chk("t4_byte", sq[NB-1], 8'h5A);
        chk("t4_ack", aq[NB-1], 2'b01);

        // reset while waiting for tx_rdy aborts without ack
        do_reset();
        cyc(2'b01, 16'h0077, 1'b0);
        cyc(2'b01, 16'h0077, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t5_mid");
        @(posedge clk); #1;
        chk("t5_noack", ack, 2'b00);
        rst_n = 1'b1;
        model_reset();
        rq = 2'b01;
        for (int c = 0; c < 9; c++) begin
            cyc(rq, 16'h0077, 1'b1);
            if (ack[0]) rq = 2'b00;
        end
        chk("t5_nstrobe", sq.size(), NB);
        chk("t5_byte", sq[NB-1], 8'h77);

        // randomized requesters against the reference model
        do_reset();
        rreq = '0;
        rdat = 16'($urandom);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_wen", data_wen, 1'b1);
                chk("rnd_rst_busy", busy, 1'b0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                model_reset();
            end
            cyc(rreq, rdat, ($urandom_range(0, 9) < 7));
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) begin
                    rreq[i] = ($urandom_range(0, 4) == 0);
                    rdat[8*i +: 8] = 8'($urandom);
                end else if (!rreq[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        rreq[i] = 1'b1;
                        rdat[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rreq[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    rdat[8*i +: 8] = 8'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
